tmp_spi_reader: RTL and testbench

- Memory-mapped temperature-sensor peripheral that fills the TMP slot of the peripheral interconnect.
- It uses the same slot interface as the timer: one address bit, a write enable, 32-bit write data and 32-bit read data.
- Reads a 16-bit frame from a TMP121-class SPI sensor: read-only SPI, CPOL=0, MSB first, D15..D3 = 13-bit two's-complement temperature at 0.0625 °C/LSB.
- Supports single-shot and periodic (auto) acquisition; the CPU polls status and reads the result.

---
 rtl/tmp_spi_pkg.sv | 31 +++
 rtl/tmp_spi_reader_spi_clk_tick.sv | 29 ++
 rtl/tmp_spi_reader.sv | 158 +++++++++++++++
 tb/tb_tmp_spi_reader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmp_spi_pkg.sv
// Shared definitions for the TMP121-class SPI temperature reader: FSM states,
// register map, CTRL/STATUS bit positions and the temperature field layout.
package tmp_spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_e;

  localparam logic REG_CTRL = 1'b0;
  localparam logic REG_DATA = 1'b1;

  localparam int CTRL_START = 0;
  localparam int CTRL_AUTO  = 1;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_AUTO = 2;

  localparam int TEMP_LSB  = 3;
  localparam int TEMP_BITS = 13;

  // Sign-extend the 13-bit two's-complement reading to a full CPU word.
  function automatic logic [31:0] sext_temp(input logic [TEMP_BITS-1:0] t);
    return {{(32 - TEMP_BITS){t[TEMP_BITS-1]}}, t};
  endfunction

endpackage

// File: rtl/tmp_spi_reader_spi_clk_tick.sv
// Half-period timebase for SCLK: pulses tick_o every CLK_DIV cycles and
// restarts from zero whenever clr_i is asserted.
module spi_clk_tick #(
  parameter int CLK_DIV = 50
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CW'(CLK_DIV - 1));

  always_comb begin
    cnt_d = (clr_i || tick_o) ? '0 : cnt_q + CW'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of process order.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tmp_spi_reader.sv
// Memory-mapped reader for a TMP121-class sensor: single-shot or periodic
// 16-bit SPI frames, with the 13-bit temperature exposed sign-extended.
module tmp_spi_reader
  import tmp_spi_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int AUTO_GAP   = 25_000_000,
  parameter int FRAME_BITS = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        addr_bit2_i,
  input  logic        we_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        sclk_o,
  output logic        cs_n_o,
  input  logic        miso_i
);

  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int GW = $clog2(AUTO_GAP + 1);

  state_e                state_q, state_d;
  logic                  phase_q, phase_d;   // 0 = SCLK low half, 1 = high half
  logic [BW-1:0]         bit_q, bit_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [TEMP_BITS-1:0]  data_q, data_d;
  logic                  done_q, done_d;
  logic                  auto_q, auto_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_n_q, cs_n_d;

  logic        tick, tick_clr, busy;
  logic        ctrl_we, start_req, auto_rise;
  logic [31:0] status;
  logic        unused_wdata;

  assign unused_wdata = ^data_i[31:2];

  assign ctrl_we   = we_i && (addr_bit2_i == REG_CTRL);
  assign start_req = ctrl_we && data_i[CTRL_START];
  assign auto_rise = ctrl_we && data_i[CTRL_AUTO] && !auto_q;
  assign busy      = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
  assign tick_clr  = (state_d != state_q);

  spi_clk_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (tick_clr),
    .tick_o (tick)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    done_d  = done_q;
    auto_d  = auto_q;

    if (ctrl_we) begin
      done_d = 1'b0;
      auto_d = data_i[CTRL_AUTO];
    end

    case (state_q)
      IDLE: begin
        if (start_req || auto_rise) state_d = SETUP;
      end
      SETUP: begin
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            shreg_d = {shreg_q[FRAME_BITS-2:0], miso_i};
          end else begin
            phase_d = 1'b0;
            if (bit_q == BW'(FRAME_BITS - 1)) state_d = HOLD;
            else                              bit_d   = bit_q + BW'(1);
          end
        end
      end
      HOLD: begin
        if (tick) begin
          // Frame complete: publish atomically; the set outranks a same-cycle clear.
          data_d  = shreg_q[TEMP_LSB +: TEMP_BITS];
          done_d  = 1'b1;
          state_d = auto_d ? GAP : IDLE;
        end
      end
      GAP: begin
        if (start_req)                          state_d = SETUP;
        else if (!auto_d)                       state_d = IDLE;
        else if (gap_q == GW'(AUTO_GAP - 1))    state_d = SETUP;
        else                                    gap_d   = gap_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      phase_d = 1'b0;
      bit_d   = '0;
      gap_d   = '0;
    end

    cs_n_d = !((state_d == SETUP) || (state_d == SHIFT) || (state_d == HOLD));
    sclk_d = (state_d == SHIFT) && phase_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      auto_q  <= 1'b0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      auto_q  <= auto_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign sclk_o = sclk_q;
  assign cs_n_o = cs_n_q;

  always_comb begin
    status            = '0;
    status[STAT_BUSY] = busy;
    status[STAT_DONE] = done_q;
    status[STAT_AUTO] = auto_q;
  end

  assign data_o = (addr_bit2_i == REG_DATA) ? sext_temp(data_q) : status;

endmodule

// File: tb/tb_tmp_spi_reader.sv
// Scoreboard bench for tmp_spi_reader: a sensor model serves 16-bit frames,
// expected readings are queued at frame start and compared when done rises.
module tb_tmp_spi_reader;

  localparam int CLK_DIV    = 2;
  localparam int AUTO_GAP   = 100;
  localparam int FRAME_BITS = 16;
  localparam int FRAME_LOW  = (2 + 2 * FRAME_BITS) * CLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        addr = 1'b0;
  logic        we = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        sclk, cs_n;
  logic        miso = 1'b0;

  always #5 clk = ~clk;

  tmp_spi_reader #(
    .CLK_DIV    (CLK_DIV),
    .AUTO_GAP   (AUTO_GAP),
    .FRAME_BITS (FRAME_BITS)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .addr_bit2_i (addr),
    .we_i        (we),
    .data_i      (wdata),
    .data_o      (rdata),
    .sclk_o      (sclk),
    .cs_n_o      (cs_n),
    .miso_i      (miso)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int ecount = 0;
  logic [31:0] exp_q[$];

  always @(posedge clk) ecount++;

  // Sensor model and bus monitor: shifts a new bit out after each SCLK fall,
  // and counts SCLK rises, CS falls, CS-low cycles and the last CS-high run.
  logic [15:0] sensor_word = '0;
  int mon_rises = 0, mon_falls = 0, mon_low = 0, mon_high_run = 0, mon_last_gap = 0;
  int bit_idx = FRAME_BITS - 1;
  logic prev_cs = 1'b1, prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (!cs_n && prev_cs) begin
      mon_falls++;
      mon_last_gap = mon_high_run;
      mon_high_run = 0;
      bit_idx = FRAME_BITS - 1;
    end else if (!cs_n && !sclk && prev_sclk && bit_idx > 0) begin
      bit_idx--;
    end
    if (sclk && !prev_sclk) mon_rises++;
    if (cs_n) mon_high_run++;
    else      mon_low++;
    miso = sensor_word[bit_idx];
    prev_cs = cs_n;
    prev_sclk = sclk;
  end

  function automatic logic [31:0] exp_temp(input logic [15:0] w);
    return {{19{w[15]}}, w[15:3]};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_reg(input logic a, output logic [31:0] v);
    addr = a;
    #1;
    v = rdata;
  endtask

  task automatic write_ctrl(input logic [31:0] v, output int edge_n);
    addr = 1'b0;
    we = 1'b1;
    wdata = v;
    @(posedge clk);
    #1;
    edge_n = ecount;
    we = 1'b0;
    wdata = '0;
  endtask

  task automatic wait_done(input int budget, output int seen_at, output bit ok);
    logic [31:0] v;
    ok = 1'b0;
    seen_at = 0;
    for (int i = 0; i < budget; i++) begin
      read_reg(1'b0, v);
      if (v[1]) begin
        ok = 1'b1;
        seen_at = ecount;
        return;
      end
      step(1);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
    read_reg(1'b0, v);
    tests_run++;
    if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_status: got %h expected %h", v, 32'h0); end
    tests_run++;
    if (cs_n !== 1'b1) begin tests_failed++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    tests_run++;
    if (sclk !== 1'b0) begin tests_failed++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    read_reg(1'b1, v);
    tests_run++;
    if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_data: got %h expected %h", v, 32'h0); end
  endtask

  task automatic test_single_pos();
    int n0, t, r0, l0;
    bit ok;
    logic [31:0] v, e;
    sensor_word = 16'h0C80;
    r0 = mon_rises;
    l0 = mon_low;
    exp_q.push_back(exp_temp(sensor_word));
    write_ctrl(32'h1, n0);
    tests_run++;
    if (cs_n !== 1'b0) begin tests_failed++; $display("FAIL pos_cs_fall: got %b expected 0", cs_n); end
    wait_done(300, t, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL pos_done_timeout: got none expected done"); end
    else if (t - n0 != FRAME_LOW) begin tests_failed++; $display("FAIL pos_done_latency: got %0d expected %0d", t - n0, FRAME_LOW); end
    tests_run++;
    if (mon_low - l0 != FRAME_LOW) begin tests_failed++; $display("FAIL pos_cs_low: got %0d expected %0d", mon_low - l0, FRAME_LOW); end
    tests_run++;
    if (mon_rises - r0 != FRAME_BITS) begin tests_failed++; $display("FAIL pos_sclk_rises: got %0d expected %0d", mon_rises - r0, FRAME_BITS); end
    read_reg(1'b1, v);
    tests_run++;
    if (exp_q.size() == 0) begin tests_failed++; $display("FAIL pos_data: got %h expected nothing queued", v); end
    else begin
      e = exp_q.pop_front();
      if (v !== e) begin tests_failed++; $display("FAIL pos_data: got %h expected %h", v, e); end
    end
    read_reg(1'b0, v);
    tests_run++;
    if (v !== 32'h2) begin tests_failed++; $display("FAIL pos_status: got %h expected %h", v, 32'h2); end
  endtask

  task automatic test_single_neg();
    int n0, t, r0;
    bit ok;
    logic [31:0] v, e;
    sensor_word = 16'hE700;
    r0 = mon_rises;
    exp_q.push_back(exp_temp(sensor_word));
    write_ctrl(32'h1, n0);
    step(30);
    read_reg(1'b1, v);
    tests_run++;
    if (v !== 32'h0000_0190) begin tests_failed++; $display("FAIL neg_data_hold: got %h expected %h", v, 32'h0000_0190); end
    wait_done(300, t, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL neg_done_timeout: got none expected done"); end
    else if (mon_rises - r0 != FRAME_BITS) begin tests_failed++; $display("FAIL neg_sclk_rises: got %0d expected %0d", mon_rises - r0, FRAME_BITS); end
    read_reg(1'b1, v);
    tests_run++;
    if (exp_q.size() == 0) begin tests_failed++; $display("FAIL neg_data: got %h expected nothing queued", v); end
    else begin
      e = exp_q.pop_front();
      if (v !== e) begin tests_failed++; $display("FAIL neg_data: got %h expected %h", v, e); end
    end
    tests_run++;
    if (v !== 32'hFFFF_FCE0) begin tests_failed++; $display("FAIL neg_data_const: got %h expected %h", v, 32'hFFFF_FCE0); end
  endtask

  task automatic test_start_while_busy();
    int n0, dummy, r0, f0;
    logic [31:0] v, e;
    sensor_word = 16'h0C80;
    r0 = mon_rises;
    f0 = mon_falls;
    exp_q.push_back(exp_temp(sensor_word));
    write_ctrl(32'h1, n0);
    step(19);
    write_ctrl(32'h1, dummy);
    read_reg(1'b0, v);
    tests_run++;
    if (v !== 32'h1) begin tests_failed++; $display("FAIL busy_status_mid: got %h expected %h", v, 32'h1); end
    step(FRAME_LOW - 1 - (dummy - n0));
    write_ctrl(32'h0, dummy);
    read_reg(1'b0, v);
    tests_run++;
    if (v !== 32'h2) begin tests_failed++; $display("FAIL busy_done_wins: got %h expected %h", v, 32'h2); end
    tests_run++;
    if (mon_rises - r0 != FRAME_BITS) begin tests_failed++; $display("FAIL busy_sclk_rises: got %0d expected %0d", mon_rises - r0, FRAME_BITS); end
    tests_run++;
    if (mon_falls - f0 != 1) begin tests_failed++; $display("FAIL busy_cs_falls: got %0d expected 1", mon_falls - f0); end
    read_reg(1'b1, v);
    tests_run++;
    if (exp_q.size() == 0) begin tests_failed++; $display("FAIL busy_data: got %h expected nothing queued", v); end
    else begin
      e = exp_q.pop_front();
      if (v !== e) begin tests_failed++; $display("FAIL busy_data: got %h expected %h", v, e); end
    end
  endtask

  task automatic test_back_to_back();
    int n0, t, dummy, f0, f1;
    bit ok;
    logic [31:0] v, e;
    sensor_word = 16'h0320;
    f0 = mon_falls;
    exp_q.push_back(exp_temp(sensor_word));
    write_ctrl(32'h2, n0);
    wait_done(300, t, ok);
    read_reg(1'b1, v);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL auto_done1_timeout: got none expected done"); end
    else if (exp_q.size() == 0) begin tests_failed++; $display("FAIL auto_data1: got %h expected nothing queued", v); end
    else begin
      e = exp_q.pop_front();
      if (v !== e) begin tests_failed++; $display("FAIL auto_data1: got %h expected %h", v, e); end
    end
    sensor_word = 16'hFFF8;
    exp_q.push_back(exp_temp(sensor_word));
    write_ctrl(32'h2, dummy);
    for (int i = 0; i < 300 && mon_falls < f0 + 2; i++) step(1);
    tests_run++;
    if (mon_falls < f0 + 2) begin tests_failed++; $display("FAIL auto_restart_timeout: got %0d falls expected %0d", mon_falls - f0, 2); end
    else if (mon_last_gap != AUTO_GAP) begin tests_failed++; $display("FAIL auto_gap: got %0d expected %0d", mon_last_gap, AUTO_GAP); end
    write_ctrl(32'h0, dummy);
    wait_done(300, t, ok);
    read_reg(1'b1, v);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL auto_done2_timeout: got none expected done"); end
    else if (exp_q.size() == 0) begin tests_failed++; $display("FAIL auto_data2: got %h expected nothing queued", v); end
    else begin
      e = exp_q.pop_front();
      if (v !== e) begin tests_failed++; $display("FAIL auto_data2: got %h expected %h", v, e); end
    end
    f1 = mon_falls;
    step(3 * AUTO_GAP);
    tests_run++;
    if (mon_falls != f1) begin tests_failed++; $display("FAIL auto_stopped: got %0d extra falls expected 0", mon_falls - f1); end
    read_reg(1'b0, v);
    tests_run++;
    if (v !== 32'h2) begin tests_failed++; $display("FAIL auto_status_idle: got %h expected %h", v, 32'h2); end
  endtask

  task automatic test_reset_mid_frame();
    int n0, t, r0;
    bit ok;
    logic [31:0] v, e;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(1);
    sensor_word = 16'h0C80;
    r0 = mon_rises;
    write_ctrl(32'h1, n0);
    for (int i = 0; i < 200 && mon_rises - r0 < 8; i++) step(1);
    tests_run++;
    if (mon_rises - r0 < 8) begin tests_failed++; $display("FAIL midrst_wait: got %0d rises expected 8", mon_rises - r0); end
    rst = 1'b1;
    step(1);
    tests_run++;
    if (cs_n !== 1'b1 || sclk !== 1'b0) begin tests_failed++; $display("FAIL midrst_pins: got cs_n=%b sclk=%b expected cs_n=1 sclk=0", cs_n, sclk); end
    read_reg(1'b1, v);
    tests_run++;
    if (v !== 32'h0) begin tests_failed++; $display("FAIL midrst_data: got %h expected %h", v, 32'h0); end
    read_reg(1'b0, v);
    tests_run++;
    if (v !== 32'h0) begin tests_failed++; $display("FAIL midrst_status: got %h expected %h", v, 32'h0); end
    rst = 1'b0;
    step(2);
    r0 = mon_rises;
    exp_q.push_back(exp_temp(sensor_word));
    write_ctrl(32'h1, n0);
    wait_done(300, t, ok);
    tests_run++;
    if (!ok) begin tests_failed++; $display("FAIL postrst_done_timeout: got none expected done"); end
    else if (t - n0 != FRAME_LOW) begin tests_failed++; $display("FAIL postrst_latency: got %0d expected %0d", t - n0, FRAME_LOW); end
    tests_run++;
    if (mon_rises - r0 != FRAME_BITS) begin tests_failed++; $display("FAIL postrst_sclk_rises: got %0d expected %0d", mon_rises - r0, FRAME_BITS); end
    read_reg(1'b1, v);
    tests_run++;
    if (exp_q.size() == 0) begin tests_failed++; $display("FAIL postrst_data: got %h expected nothing queued", v); end
    else begin
      e = exp_q.pop_front();
      if (v !== e) begin tests_failed++; $display("FAIL postrst_data: got %h expected %h", v, e); end
    end
  endtask

  initial begin
    test_reset();
    test_single_pos();
    test_single_neg();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_frame();
    tests_run++;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL scoreboard_leftover: got %0d expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
